engine_round_sequencer: RTL and testbench

Sequencer for the AES-128 encryption datapath. It accepts one plaintext block over a valid/ready handshake and waits until the key generator reports its round keys ready. It then steps the combinational round-function datapath through the initial AddRoundKey, 9 full rounds and the final round (no MixColumns), and presents the ciphertext over a valid/ready handshake. It sits between the engine's input interface, `engine_key_generator` (round keys plus `transformer_start`) and the round-function datapath, and owns the 128-bit state register.

---
 rtl/aes_engine_pkg.sv | 29 ++
 rtl/engine_round_sequencer_if.sv | 25 ++
 rtl/engine_rk_mux.sv | 11 +
 rtl/engine_round_sequencer.sv | 115 +++++++++++
 tb/tb_engine_round_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_engine_pkg.sv
// Shared AES engine definitions: sizes, sequencer state encoding and the
// round-key slice helper used by the key muxes.
package aes_engine_pkg;
    localparam int AES_ROUNDS  = 10;
    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEYS_W  = (AES_ROUNDS + 1) * AES_BLOCK_W;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_WAIT_KEY,
        SEQ_ARK0,
        SEQ_ROUND,
        SEQ_FINAL,
        SEQ_HOLD
    } seq_state_e;

    // Pick key r out of the flattened key bus; indices above AES_ROUNDS yield 0.
    function automatic logic [AES_BLOCK_W-1:0] rk_slice(
        input logic [AES_KEYS_W-1:0] keys,
        input logic [3:0]            idx
    );
        logic [AES_BLOCK_W-1:0] k;
        k = '0;
        for (int r = 0; r <= AES_ROUNDS; r++) begin
            if (idx == 4'(r)) k = keys[r*AES_BLOCK_W +: AES_BLOCK_W];
        end
        return k;
    endfunction
endpackage

// File: rtl/engine_round_sequencer_if.sv
// Plaintext-in / ciphertext-out stream handshake of the round sequencer.
interface engine_round_sequencer_if
    import aes_engine_pkg::*;
#(
    parameter int BLOCK_W = AES_BLOCK_W
) ();
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] block_in;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] block_out;

    // Producer/consumer side (engine front end)
    modport master (
        output in_valid, block_in, out_ready,
        input  in_ready, out_valid, block_out
    );

    // Sequencer side
    modport slave (
        input  in_valid, block_in, out_ready,
        output in_ready, out_valid, block_out
    );
endinterface

// File: rtl/engine_rk_mux.sv
// Combinational 11:1 round-key selector; shared with the decryption sequencer.
module engine_rk_mux
    import aes_engine_pkg::*;
(
    input  logic [AES_KEYS_W-1:0]  round_keys,
    input  logic [3:0]             round_idx,
    output logic [AES_BLOCK_W-1:0] round_key
);
    // Select the key for the current round
    always_comb round_key = rk_slice(round_keys, round_idx);
endmodule

// File: rtl/engine_round_sequencer.sv
// AES-128 round sequencer: owns the state register and walks the external
// round datapath through ARK0, rounds 1..ROUNDS-1 and the final round.
// ROUNDS/BLOCK_W must stay at the AES-128 values; the key mux is fixed-size.
module engine_round_sequencer
    import aes_engine_pkg::*;
#(
    parameter int ROUNDS  = AES_ROUNDS,
    parameter int BLOCK_W = AES_BLOCK_W
) (
    input  logic                          clk,
    input  logic                          rst_,
    input  logic                          keys_ready,
    input  logic [(ROUNDS+1)*BLOCK_W-1:0] round_keys,
    engine_round_sequencer_if.slave       io,
    output logic [BLOCK_W-1:0]            round_in,
    output logic [BLOCK_W-1:0]            round_key,
    output logic                          round_final,
    input  logic [BLOCK_W-1:0]            round_out,
    output logic [3:0]                    round_idx,
    output logic                          busy,
    output logic                          abort
);
    seq_state_e         state_q, state_d;
    logic [BLOCK_W-1:0] st_q, st_d;
    logic [3:0]         idx_q, idx_d;
    logic               abort_q, abort_d;

    engine_rk_mux u_rk_mux (
        .round_keys (round_keys),
        .round_idx  (idx_q),
        .round_key  (round_key)
    );

    assign io.in_ready  = (state_q == SEQ_IDLE);
    assign io.out_valid = (state_q == SEQ_HOLD);
    assign io.block_out = st_q;
    assign round_in     = st_q;
    assign round_final  = (state_q == SEQ_FINAL);
    assign round_idx    = idx_q;
    assign busy         = (state_q != SEQ_IDLE);
    assign abort        = abort_q;

    // State, data and round-index registers; reset discards any block in flight
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= SEQ_IDLE;
            st_q    <= '0;
            idx_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            idx_q   <= idx_d;
            abort_q <= abort_d;
        end
    end

    // Next-state, state-register and round-index update
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        idx_d   = idx_q;
        abort_d = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (io.in_valid) begin
                    st_d    = io.block_in;
                    idx_d   = '0;
                    state_d = keys_ready ? SEQ_ARK0 : SEQ_WAIT_KEY;
                end
            end
            SEQ_WAIT_KEY: begin
                if (keys_ready) state_d = SEQ_ARK0;
            end
            SEQ_ARK0: begin
                if (!keys_ready) begin
                    state_d = SEQ_IDLE;
                    abort_d = 1'b1;
                end else begin
                    // idx_q is 0 here, so round_key is key 0
                    st_d    = st_q ^ round_key;
                    idx_d   = 4'd1;
                    state_d = SEQ_ROUND;
                end
            end
            SEQ_ROUND: begin
                if (!keys_ready) begin
                    state_d = SEQ_IDLE;
                    abort_d = 1'b1;
                end else begin
                    st_d  = round_out;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'(ROUNDS - 1)) state_d = SEQ_FINAL;
                end
            end
            SEQ_FINAL: begin
                if (!keys_ready) begin
                    state_d = SEQ_IDLE;
                    abort_d = 1'b1;
                end else begin
                    st_d    = round_out;
                    state_d = SEQ_HOLD;
                end
            end
            SEQ_HOLD: begin
                // Result is complete; key loss no longer matters here
                if (io.out_ready) begin
                    state_d = SEQ_IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end
endmodule

// File: tb/tb_engine_round_sequencer.sv
// Directed bench for engine_round_sequencer with a reference AES round datapath.
module tb_engine_round_sequencer;
    import aes_engine_pkg::*;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT3  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT3  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] PT4  = 128'hdeadbeef00000000cafef00d12345678;

    logic                  clk = 1'b0;
    logic                  rst_;
    logic                  keys_ready;
    logic [AES_KEYS_W-1:0] round_keys;
    logic [127:0]          round_in, round_key, round_out;
    logic                  round_final;
    logic [3:0]            round_idx;
    logic                  busy, abort;

    int tests = 0;
    int fails = 0;

    engine_round_sequencer_if bus ();

    engine_round_sequencer dut (
        .clk         (clk),
        .rst_        (rst_),
        .keys_ready  (keys_ready),
        .round_keys  (round_keys),
        .io          (bus),
        .round_in    (round_in),
        .round_key   (round_key),
        .round_final (round_final),
        .round_out   (round_out),
        .round_idx   (round_idx),
        .busy        (busy),
        .abort       (abort)
    );

    always #5 clk = ~clk;

    // ---------------- reference AES round model ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p, r, s;
        p = x; r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o;
    endfunction

    function automatic logic [AES_KEYS_W-1:0] key_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [AES_KEYS_W-1:0] rk;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t[31:24] = t[31:24] ^ rc;
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [AES_KEYS_W-1:0] rk;
        logic [127:0] s;
        rk = key_expand(key);
        s = pt ^ rk[127:0];
        for (int r = 1; r < 10; r++) s = mix(sub_shift(s)) ^ rk[r*128 +: 128];
        return sub_shift(s) ^ rk[10*128 +: 128];
    endfunction

    // Reference round datapath driven by the sequencer
    always_comb round_out = round_final ? (sub_shift(round_in) ^ round_key)
                                        : (mix(sub_shift(round_in)) ^ round_key);

    // ---------------- helpers ----------------
    task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until out_valid, bounded by limit
    task automatic wait_ov(input int limit, output int n);
        n = 0;
        while (!bus.out_valid && n < limit) begin
            tick();
            n++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  n;
        logic flag;
        logic [127:0] exp2, exp4;
        exp2 = aes_enc(PT2, KEY1);
        exp4 = aes_enc(PT4, KEY1);

        rst_ = 1'b0; keys_ready = 1'b0; round_keys = '0;
        bus.in_valid = 1'b0; bus.block_in = '0; bus.out_ready = 1'b0;
        #12;
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_in_ready", bus.in_ready, 1'b1);
        chk_b("rst_out_valid", bus.out_valid, 1'b0);
        chk_b("rst_abort", abort, 1'b0);
        chk_w("rst_idx", 128'(round_idx), 128'(0));
        chk_w("rst_block_out", bus.block_out, 128'(0));
        tick();
        rst_ = 1'b1;
        tick();

        // FIPS-197 C.1 with per-cycle round index and latency
        round_keys = key_expand(KEY1);
        keys_ready = 1'b1;
        bus.block_in = PT1; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk_w("ark0_idx", 128'(round_idx), 128'(0));
        chk_b("ark0_in_ready", bus.in_ready, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk_w($sformatf("idx_c%0d", k), 128'(round_idx), 128'((k > 10) ? 10 : k));
            chk_b($sformatf("ov_c%0d", k), bus.out_valid, k == 11);
            chk_b($sformatf("final_c%0d", k), round_final, k == 10);
        end
        chk_w("fips_ct", bus.block_out, CT1);
        bus.out_ready = 1'b1;
        tick();
        chk_b("fips_back_idle", bus.in_ready, 1'b1);
        chk_b("fips_ov_drop", bus.out_valid, 1'b0);

        // keys_ready low for 5 cycles at accept
        keys_ready = 1'b0;
        bus.block_in = PT1; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            flag = flag & busy & !bus.in_ready & !bus.out_valid & (round_idx == 4'd0) & !abort;
            if (i == 4) keys_ready = 1'b1;
            tick();
        end
        chk_b("waitkey_hold", flag, 1'b1);
        wait_ov(30, n);
        chk_w("waitkey_latency", 128'(n + 5), 128'(16));
        chk_w("waitkey_ct", bus.block_out, CT1);
        tick();

        // Key loss during round 4
        bus.block_in = PT2; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        chk_w("loss_idx4", 128'(round_idx), 128'(4));
        keys_ready = 1'b0;
        tick();
        chk_b("loss_abort", abort, 1'b1);
        chk_b("loss_busy", busy, 1'b0);
        chk_b("loss_in_ready", bus.in_ready, 1'b1);
        keys_ready = 1'b1;
        tick();
        chk_b("loss_abort_pulse", abort, 1'b0);
        flag = 1'b0;
        for (int i = 0; i < 15; i++) begin
            flag = flag | bus.out_valid;
            tick();
        end
        chk_b("loss_no_ov", flag, 1'b0);

        // Backpressure in HOLD, with keys_ready dropped meanwhile
        bus.out_ready = 1'b0;
        bus.block_in = PT2; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_ov(30, n);
        chk_w("bp_latency", 128'(n), 128'(11));
        chk_w("bp_ct", bus.block_out, exp2);
        flag = 1'b1;
        for (int i = 0; i < 20; i++) begin
            flag = flag & (bus.block_out == exp2) & !bus.in_ready & bus.out_valid;
            keys_ready = !(i >= 5 && i < 10);
            tick();
        end
        chk_b("bp_stable", flag, 1'b1);
        keys_ready = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        chk_b("bp_release_idle", bus.in_ready, 1'b1);
        chk_b("bp_release_ov", bus.out_valid, 1'b0);

        // Asynchronous reset during round 6
        round_keys = key_expand(KEY2);
        bus.block_in = PT3; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (6) tick();
        chk_w("rst6_idx", 128'(round_idx), 128'(6));
        #2 rst_ = 1'b0;
        #1;
        chk_b("rst6_busy", busy, 1'b0);
        chk_w("rst6_idx0", 128'(round_idx), 128'(0));
        chk_w("rst6_block", bus.block_out, 128'(0));
        chk_b("rst6_ov", bus.out_valid, 1'b0);
        chk_b("rst6_abort", abort, 1'b0);
        tick();
        rst_ = 1'b1;
        tick();
        chk_b("rst6_abort_after", abort, 1'b0);
        bus.block_in = PT3; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_ov(30, n);
        chk_w("rst6_latency", 128'(n), 128'(11));
        chk_w("rst6_ct", bus.block_out, CT3);
        tick();

        // Back-to-back blocks with in_valid held high
        round_keys = key_expand(KEY1);
        bus.block_in = PT1; bus.in_valid = 1'b1;
        tick();
        bus.block_in = PT4;
        wait_ov(30, n);
        chk_w("b2b_lat1", 128'(n), 128'(11));
        chk_w("b2b_ct1", bus.block_out, CT1);
        tick();
        chk_b("b2b_idle12", bus.in_ready, 1'b1);
        tick();
        chk_b("b2b_accept13", busy, 1'b1);
        bus.in_valid = 1'b0;
        wait_ov(30, n);
        chk_w("b2b_lat2", 128'(n), 128'(11));
        chk_w("b2b_ct2", bus.block_out, exp4);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
